bp_l15_return_router: RTL and testbench

//  L1.5 -> BP return-path front end. Sits between the L1.5 return channel and the L1.5 transducer.

---
 rtl/bp_l15_return_router.sv | 129 ++++++++++++
 tb/tb_bp_l15_return_router.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_l15_return_router.sv
// L1.5 return-path front end: forwards returns to the transducer and expands EVICT_REQ into
// per-way dcache tag invalidates. Optional BP_L15_RETURN_ROUTER_STATS_EN adds inval_cnt_o.
module bp_l15_return_router
  #(parameter int lce_sets_p     = 64
   ,parameter int lce_assoc_p    = 8
   ,parameter int block_offset_p = 6
   ,localparam int index_width_lp = $clog2(lce_sets_p)
   ,localparam int way_width_lp   = $clog2(lce_assoc_p)
   )
   (input  logic                      clk_i
   ,input  logic                      reset_i
   ,input  logic                      l15_transducer_val
   ,input  logic [3:0]                l15_transducer_returntype
   ,input  logic [63:0]               l15_transducer_data_0
   ,input  logic [63:0]               l15_transducer_data_1
   ,input  logic [11:0]               l15_transducer_inval_address_15_4
   ,input  logic                      l15_transducer_inval_dcache_inval
   ,input  logic                      l15_transducer_inval_dcache_all_way
   ,input  logic [1:0]                l15_transducer_inval_way
   ,output logic                      transducer_l15_req_ack
   ,output logic                      rtn_v_o
   ,output logic [3:0]                rtn_type_o
   ,output logic [63:0]               rtn_data_0_o
   ,output logic [63:0]               rtn_data_1_o
   ,input  logic                      rtn_ack_i
   ,output logic                      inval_v_o
   ,output logic [index_width_lp-1:0] inval_index_o
   ,output logic [way_width_lp-1:0]   inval_way_o
   ,input  logic                      inval_yumi_i
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
   ,output logic [31:0]               inval_cnt_o
`endif
   ,output logic                      busy_o
   );

   localparam logic [3:0] evict_req_lp = 4'b0011;

   typedef enum logic [1:0] {e_idle, e_inval, e_ack} state_e;

   state_e state_reg, state_next;

   logic [index_width_lp-1:0] index_reg;
   logic                      all_way_reg;
   logic [way_width_lp-1:0]   way_cnt_reg;

   logic [15:0] inval_addr;
   logic        is_evict;
   logic        capture;
   logic        last_way;

   assign inval_addr = {l15_transducer_inval_address_15_4, 4'b0000};
   assign is_evict   = l15_transducer_val && (l15_transducer_returntype == evict_req_lp);
   assign capture    = (state_reg == e_idle) && is_evict && l15_transducer_inval_dcache_inval;
   assign last_way   = !all_way_reg || (way_cnt_reg == way_width_lp'(lce_assoc_p - 1));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         state_reg <= e_idle;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         e_idle:  if (is_evict)
                     state_next = l15_transducer_inval_dcache_inval ? e_inval : e_ack;
         e_inval: if (inval_yumi_i && last_way)
                     state_next = e_ack;
         e_ack:   state_next = e_idle;
         default: state_next = e_idle;
      endcase
   end

   always_comb begin
      rtn_v_o                = (state_reg == e_idle) && l15_transducer_val && !is_evict;
      rtn_type_o             = l15_transducer_returntype;
      rtn_data_0_o           = l15_transducer_data_0;
      rtn_data_1_o           = l15_transducer_data_1;
      inval_v_o              = (state_reg == e_inval);
      inval_index_o          = index_reg;
      inval_way_o            = way_cnt_reg;
      transducer_l15_req_ack = (rtn_v_o && rtn_ack_i) || (state_reg == e_ack);
      busy_o                 = (state_reg != e_idle);
   end

   // Walk stops at the last way; the counter never wraps.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         index_reg   <= '0;
         all_way_reg <= 1'b0;
         way_cnt_reg <= '0;
      end else if (capture) begin
         index_reg   <= inval_addr[block_offset_p +: index_width_lp];
         all_way_reg <= l15_transducer_inval_dcache_all_way;
         way_cnt_reg <= l15_transducer_inval_dcache_all_way
                        ? '0 : way_width_lp'(l15_transducer_inval_way);
      end else if ((state_reg == e_inval) && inval_yumi_i && !last_way) begin
         way_cnt_reg <= way_cnt_reg + 1'b1;
      end
   end

`ifdef BP_L15_RETURN_ROUTER_STATS_EN
   logic [31:0] inval_cnt_reg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         inval_cnt_reg <= '0;
      else if ((state_reg == e_ack) && (inval_cnt_reg != 32'hFFFF_FFFF))
         inval_cnt_reg <= inval_cnt_reg + 32'd1;
   end

   assign inval_cnt_o = inval_cnt_reg;
`endif

`ifndef SYNTHESIS
   // A held, unacknowledged return must not change under the router.
   a_return_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (l15_transducer_val && !transducer_l15_req_ack) |=>
         (!l15_transducer_val ||
          $stable({l15_transducer_returntype, l15_transducer_inval_address_15_4,
                   l15_transducer_inval_dcache_inval, l15_transducer_inval_dcache_all_way,
                   l15_transducer_inval_way})));

   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
      inval_yumi_i |-> inval_v_o);
`endif

endmodule

// File: tb/tb_bp_l15_return_router.sv
// Directed bench for bp_l15_return_router: forwarding, single/all-way invalidates, stalls,
// icache-only evicts and reset abort.
module tb_bp_l15_return_router;

   localparam logic [3:0] load_ret_lp  = 4'b0000;
   localparam logic [3:0] st_ack_lp    = 4'b0100;
   localparam logic [3:0] evict_req_lp = 4'b0011;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        val;
   logic [3:0]  rtype;
   logic [63:0] data_0, data_1;
   logic [11:0] addr_15_4;
   logic        dcache_inval, all_way;
   logic [1:0]  way_in;
   logic        req_ack;
   logic        rtn_v;
   logic [3:0]  rtn_type;
   logic [63:0] rtn_data_0, rtn_data_1;
   logic        rtn_ack;
   logic        inval_v;
   logic [5:0]  inval_index;
   logic [2:0]  inval_way;
   logic        yumi;
   logic        busy;
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
   logic [31:0] inval_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   bp_l15_return_router dut
     (.clk_i                               (clk_i)
     ,.reset_i                             (reset_i)
     ,.l15_transducer_val                  (val)
     ,.l15_transducer_returntype           (rtype)
     ,.l15_transducer_data_0               (data_0)
     ,.l15_transducer_data_1               (data_1)
     ,.l15_transducer_inval_address_15_4   (addr_15_4)
     ,.l15_transducer_inval_dcache_inval   (dcache_inval)
     ,.l15_transducer_inval_dcache_all_way (all_way)
     ,.l15_transducer_inval_way            (way_in)
     ,.transducer_l15_req_ack              (req_ack)
     ,.rtn_v_o                             (rtn_v)
     ,.rtn_type_o                          (rtn_type)
     ,.rtn_data_0_o                        (rtn_data_0)
     ,.rtn_data_1_o                        (rtn_data_1)
     ,.rtn_ack_i                           (rtn_ack)
     ,.inval_v_o                           (inval_v)
     ,.inval_index_o                       (inval_index)
     ,.inval_way_o                         (inval_way)
     ,.inval_yumi_i                        (yumi)
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
     ,.inval_cnt_o                         (inval_cnt)
`endif
     ,.busy_o                              (busy)
     );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   // Cycle in which an invalidate command should be presented.
   task automatic chk_cmd(input string tag, input logic [5:0] idx, input logic [2:0] w);
      chk({tag, ".v"},     inval_v,     1'b1);
      chk({tag, ".index"}, inval_index, idx);
      chk({tag, ".way"},   inval_way,   w);
      chk({tag, ".ack"},   req_ack,     1'b0);
      chk({tag, ".rtn_v"}, rtn_v,       1'b0);
   endtask

   task automatic start_evict(input logic [11:0] a, input logic dinv, input logic aw,
                              input logic [1:0] w);
      val          = 1'b1;
      rtype        = evict_req_lp;
      addr_15_4    = a;
      dcache_inval = dinv;
      all_way      = aw;
      way_in       = w;
   endtask

   initial begin
      reset_i = 1'b1; val = 1'b0; rtype = '0; data_0 = '0; data_1 = '0; addr_15_4 = '0;
      dcache_inval = 1'b0; all_way = 1'b0; way_in = '0; rtn_ack = 1'b0; yumi = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;

      sample();
      chk("reset.busy",  busy,    1'b0);
      chk("reset.inv_v", inval_v, 1'b0);
      chk("reset.ack",   req_ack, 1'b0);
      chk("reset.rtn_v", rtn_v,   1'b0);
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
      chk("reset.cnt",   inval_cnt, 32'd0);
`endif
      $display("txn reset: busy=%0b inval_v=%0b", busy, inval_v);

      // 1: LOAD_RET forwarded combinationally, ack follows rtn_ack_i in the same cycle
      next_cycle();
      val = 1'b1; rtype = load_ret_lp; data_0 = 64'hA5; data_1 = 64'h1234_5678_9ABC_DEF0;
      sample();
      chk("t1.rtn_v",  rtn_v,      1'b1);
      chk("t1.type",   rtn_type,   load_ret_lp);
      chk("t1.d0",     rtn_data_0, 64'hA5);
      chk("t1.d1",     rtn_data_1, 64'h1234_5678_9ABC_DEF0);
      chk("t1.noack",  req_ack,    1'b0);
      rtn_ack = 1'b1;
      #1;
      chk("t1.ack",    req_ack,    1'b1);
      $display("txn 1 LOAD_RET: rtn_v=%0b data_0=%0h req_ack=%0b", rtn_v, rtn_data_0, req_ack);
      next_cycle();
      val = 1'b0; rtn_ack = 1'b0;
      sample();
      chk("t1.idle", busy, 1'b0);

      // 2: single-way invalidate, addr 12'h030 -> index 6'h0C, way 2
      next_cycle();
      start_evict(12'h030, 1'b1, 1'b0, 2'd2);
      sample();
      chk("t2.c0.inv_v", inval_v, 1'b0);
      chk("t2.c0.ack",   req_ack, 1'b0);
      chk("t2.c0.rtn_v", rtn_v,   1'b0);
      next_cycle();
      yumi = 1'b1;
      sample();
      chk_cmd("t2.c1", 6'h0C, 3'd2);
      chk("t2.c1.busy", busy, 1'b1);
      next_cycle();
      yumi = 1'b0;
      sample();
      chk("t2.c2.inv_v", inval_v, 1'b0);
      chk("t2.c2.ack",   req_ack, 1'b1);
      next_cycle();
      val = 1'b0;
      sample();
      chk("t2.c3.ack",  req_ack, 1'b0);
      chk("t2.c3.busy", busy,    1'b0);
      $display("txn 2 single-way evict: done");

      // 3: all-way walk with no backpressure; way_in must be ignored
      next_cycle();
      start_evict(12'hFFC, 1'b1, 1'b1, 2'd3);
      sample();
      chk("t3.c0.inv_v", inval_v, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         yumi = 1'b1;
         sample();
         chk_cmd($sformatf("t3.c%0d", c), 6'h3F, 3'(c - 1));
      end
      next_cycle();
      yumi = 1'b0;
      sample();
      chk("t3.c9.inv_v", inval_v, 1'b0);
      chk("t3.c9.ack",   req_ack, 1'b1);
      next_cycle();
      val = 1'b0;
      sample();
      chk("t3.c10.busy", busy,    1'b0);
      chk("t3.c10.ack",  req_ack, 1'b0);
      $display("txn 3 all-way evict: done");

      // 4: all-way walk stalled three cycles per way
      next_cycle();
      start_evict(12'h0A8, 1'b1, 1'b1, 2'd0);
      for (int w = 0; w < 8; w++) begin
         for (int s = 0; s < 3; s++) begin
            next_cycle();
            yumi = 1'b0;
            sample();
            chk_cmd($sformatf("t4.w%0d.s%0d", w, s), 6'h2A, 3'(w));
         end
         next_cycle();
         yumi = 1'b1;
         sample();
         chk_cmd($sformatf("t4.w%0d.go", w), 6'h2A, 3'(w));
      end
      next_cycle();
      yumi = 1'b0;
      sample();
      chk("t4.ack",       req_ack, 1'b1);
      chk("t4.ack.inv_v", inval_v, 1'b0);
      next_cycle();
      val = 1'b0;
      sample();
      chk("t4.idle", busy, 1'b0);
      $display("txn 4 stalled all-way evict: done");

      // 5: icache-only evict acks on cycle 1 without any command
      next_cycle();
      start_evict(12'h555, 1'b0, 1'b1, 2'd1);
      sample();
      chk("t5.c0.inv_v", inval_v, 1'b0);
      chk("t5.c0.ack",   req_ack, 1'b0);
      chk("t5.c0.rtn_v", rtn_v,   1'b0);
      next_cycle();
      sample();
      chk("t5.c1.inv_v", inval_v, 1'b0);
      chk("t5.c1.ack",   req_ack, 1'b1);
      chk("t5.c1.rtn_v", rtn_v,   1'b0);
      next_cycle();
      val = 1'b0;
      sample();
      chk("t5.c2.ack",  req_ack, 1'b0);
      chk("t5.c2.busy", busy,    1'b0);
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
      chk("t5.cnt", inval_cnt, 32'd4);
`endif
      $display("txn 5 icache-only evict: done");

      // 6: reset during the all-way walk at way 3
      next_cycle();
      start_evict(12'h030, 1'b1, 1'b1, 2'd0);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         yumi = (c < 4);
         sample();
         chk_cmd($sformatf("t6.c%0d", c), 6'h0C, 3'(c - 1));
      end
      reset_i = 1'b1; val = 1'b0; yumi = 1'b0;
      #1;
      chk("t6.rst.inv_v", inval_v,   1'b0);
      chk("t6.rst.busy",  busy,      1'b0);
      chk("t6.rst.ack",   req_ack,   1'b0);
      chk("t6.rst.way",   inval_way, 3'd0);
      chk("t6.rst.idx",   inval_index, 6'd0);
      next_cycle();
      reset_i = 1'b0;
      sample();
      chk("t6.post.ack", req_ack, 1'b0);
      next_cycle();
      val = 1'b1; rtype = st_ack_lp; data_0 = 64'hDEAD_BEEF; data_1 = 64'h0; rtn_ack = 1'b1;
      sample();
      chk("t6.st.rtn_v", rtn_v,      1'b1);
      chk("t6.st.type",  rtn_type,   st_ack_lp);
      chk("t6.st.d0",    rtn_data_0, 64'hDEAD_BEEF);
      chk("t6.st.ack",   req_ack,    1'b1);
`ifdef BP_L15_RETURN_ROUTER_STATS_EN
      chk("t6.cnt", inval_cnt, 32'd0);
`endif
      next_cycle();
      val = 1'b0; rtn_ack = 1'b0;
      $display("txn 6 reset abort + ST_ACK: done");

      // Unknown returntype is forwarded like any other return
      next_cycle();
      val = 1'b1; rtype = 4'hF; data_1 = 64'h77; rtn_ack = 1'b0;
      sample();
      chk("t7.rtn_v", rtn_v,      1'b1);
      chk("t7.type",  rtn_type,   4'hF);
      chk("t7.d1",    rtn_data_1, 64'h77);
      chk("t7.ack",   req_ack,    1'b0);
      rtn_ack = 1'b1;
      #1;
      chk("t7.ack2",  req_ack,    1'b1);
      next_cycle();
      val = 1'b0; rtn_ack = 1'b0;
      sample();
      chk("t7.busy", busy, 1'b0);
      $display("txn 7 unknown returntype: done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
